// File: rtl/mnist_pkg.sv
// Shared types and constants for the MNIST inference sequencer.
// Pixels travel as signed Q8.8 and confidences as unsigned Q0.8.
package mnist_pkg;

    localparam int MNIST_NUM_PIXELS  = 784;
    localparam int MNIST_NUM_CLASSES = 10;
    localparam int MNIST_DIGIT_W     = $clog2(MNIST_NUM_CLASSES);

    typedef logic signed [15:0] q8_8_t;
    typedef logic        [7:0]  q0_8_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_STREAM,
        ST_WAIT_RES,
        ST_DONE
    } infer_state_t;

endpackage

// File: rtl/mnist_pix_fetch.sv
// Pixel fetch engine: walks the pixel RAM one address ahead of the stream
// and converts each raw unsigned pixel to Q8.8 as it is presented.
module mnist_pix_fetch
    import mnist_pkg::*;
#(
    parameter int NUM_PIXELS = MNIST_NUM_PIXELS,
    parameter int ADDR_W     = 10,
    parameter int PIX_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              prime,
    input  logic              stream,
    input  logic [PIX_W-1:0]  pix_rdata,
    output logic              last_pix,
    output logic              pix_rd_en,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              nn_inp_rdy,
    output q8_8_t             nn_inp_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

    logic [ADDR_W-1:0] pix_cnt_q;
    logic              fetch_next;

    // Raw pixel lands in the fractional byte, so the value is pixel/256.
    function automatic q8_8_t pix_to_q8_8(input logic [PIX_W-1:0] pix);
        return $signed({{(16 - PIX_W){1'b0}}, pix});
    endfunction

    assign last_pix   = stream && (pix_cnt_q == LAST_IDX);
    assign fetch_next = stream && !last_pix;

    // The RAM answers one cycle late, so the address always leads the
    // pixel on the bus by one; the priming cycle supplies address 0.
    assign pix_rd_en   = prime || fetch_next;
    assign pix_addr    = fetch_next ? pix_cnt_q + 1'b1 : '0;
    assign nn_inp_rdy  = stream;
    assign nn_inp_data = stream ? pix_to_q8_8(pix_rdata) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt_q <= '0;
        end else if (fetch_next) begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
        end else begin
            pix_cnt_q <= '0;
        end
    end

endmodule

// File: rtl/mnist_infer_ctrl.sv
// Sequencer for the 10-neuron MNIST datapath: streams one image as a
// gap-free burst, waits for the neurons, and hands back digit/confidence.
module mnist_infer_ctrl
    import mnist_pkg::*;
#(
    parameter int NUM_PIXELS     = MNIST_NUM_PIXELS,
    parameter int ADDR_W         = 10,
    parameter int PIX_W          = 8,
    parameter int RESULT_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     pix_rd_en,
    output logic [ADDR_W-1:0]        pix_addr,
    input  logic [PIX_W-1:0]         pix_rdata,
    output logic                     nn_inp_rdy,
    output q8_8_t                    nn_inp_data,
    input  logic                     nn_all_ready,
    input  logic [MNIST_DIGIT_W-1:0] nn_digit,
    input  q0_8_t                    nn_conf,
    output logic                     busy,
    output logic                     done,
    output logic                     result_valid,
    output logic [MNIST_DIGIT_W-1:0] result_digit,
    output q0_8_t                    result_conf,
    output logic                     err_timeout
);

    localparam int               TMO_W    = $clog2(RESULT_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESULT_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;

    infer_state_t     state_q;
    infer_state_t     state_d;
    logic [TMO_W-1:0] tmo_q;
    logic             last_pix;
    logic             accept;
    logic             capture;
    logic             expire;

    mnist_pix_fetch #(
        .NUM_PIXELS (NUM_PIXELS),
        .ADDR_W     (ADDR_W),
        .PIX_W      (PIX_W)
    ) u_fetch (
        .clk         (clk),
        .reset_n     (reset_n),
        .prime       (state_q == ST_PRIME),
        .stream      (state_q == ST_STREAM),
        .pix_rdata   (pix_rdata),
        .last_pix    (last_pix),
        .pix_rd_en   (pix_rd_en),
        .pix_addr    (pix_addr),
        .nn_inp_rdy  (nn_inp_rdy),
        .nn_inp_data (nn_inp_data)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        expire  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PRIME;
                    accept  = 1'b1;
                end
            end
            ST_PRIME:  state_d = ST_STREAM;
            ST_STREAM: begin
                if (last_pix) state_d = ST_WAIT_RES;
            end
            // A result arriving on the expiry cycle still wins.
            ST_WAIT_RES: begin
                if (nn_all_ready) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    expire  = 1'b1;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            accept  = 1'b0;
            capture = 1'b0;
            expire  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            tmo_q        <= '0;
            result_valid <= 1'b0;
            err_timeout  <= 1'b0;
            result_digit <= '0;
            result_conf  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != ST_WAIT_RES) begin
                tmo_q <= '0;
            end else if (tmo_q != TMO_MAX) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (accept || abort) begin
                result_valid <= 1'b0;
                err_timeout  <= 1'b0;
            end else begin
                if (capture) result_valid <= 1'b1;
                if (expire)  err_timeout  <= 1'b1;
            end
            if (capture) begin
                result_digit <= nn_digit;
                result_conf  <= nn_conf;
            end
        end
    end

    assign busy = (state_q == ST_PRIME) || (state_q == ST_STREAM) || (state_q == ST_WAIT_RES);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mnist_infer_ctrl.sv
// Directed bench for mnist_infer_ctrl: table of result-wait scenarios plus
// hand-written reset, idle start/abort and back-to-back sequences.
module tb_mnist_infer_ctrl;

    localparam int NPIX = 784;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pix_rd_en;
    logic [9:0]  pix_addr;
    logic [7:0]  pix_rdata = 8'h00;
    logic        nn_inp_rdy;
    logic signed [15:0] nn_inp_data;
    logic        nn_all_ready = 1'b0;
    logic [3:0]  nn_digit = 4'h0;
    logic [7:0]  nn_conf = 8'h00;
    logic        busy;
    logic        done;
    logic        result_valid;
    logic [3:0]  result_digit;
    logic [7:0]  result_conf;
    logic        err_timeout;

    logic [7:0]  mem [0:1023];

    int checks = 0;
    int failures = 0;
    logic       prime_err;
    logic       prime_rv;
    logic [3:0] prime_digit;

    typedef struct {
        int         ready_dly;
        int         abort_dly;
        int         inject_k;
        int         abort_k;
        logic [3:0] digit;
        logic [7:0] conf;
        int         exp_done_w;
        int         exp_err_w;
        logic       exp_valid;
        logic       exp_err;
        logic [3:0] exp_digit;
        logic [7:0] exp_conf;
    } row_t;

    row_t tbl [8];

    mnist_infer_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .pix_rd_en    (pix_rd_en),
        .pix_addr     (pix_addr),
        .pix_rdata    (pix_rdata),
        .nn_inp_rdy   (nn_inp_rdy),
        .nn_inp_data  (nn_inp_data),
        .nn_all_ready (nn_all_ready),
        .nn_digit     (nn_digit),
        .nn_conf      (nn_conf),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .result_digit (result_digit),
        .result_conf  (result_conf),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pix_rd_en) pix_rdata <= mem[pix_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {20'd0, busy, done, result_valid, err_timeout, pix_rd_en, nn_inp_rdy,
                pix_addr, nn_inp_data, result_digit, result_conf};
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // first WAIT_RES cycle (or the first idle cycle after abort/reset).
    task automatic burst(input int abort_k, input int inject_k, input int reset_k);
        int rdy_cnt = 0;
        int derr = 0;
        int aerr = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("prime_rd_en", {busy, pix_rd_en, nn_inp_rdy}, 3'b110);
        chk("prime_addr", pix_addr, 10'd0);
        prime_err   = err_timeout;
        prime_rv    = result_valid;
        prime_digit = result_digit;
        for (int k = 0; k < NPIX; k++) begin
            @(negedge clk);
            start = 1'b0;
            nn_all_ready = 1'b0;
            abort = 1'b0;
            if (nn_inp_rdy === 1'b1) rdy_cnt++;
            if (nn_inp_data !== {8'h00, mem[k]}) derr++;
            if (pix_rd_en !== (k < NPIX - 1)) aerr++;
            else if (k < NPIX - 1 && pix_addr !== 10'(k + 1)) aerr++;
            if (k == inject_k) begin
                start = 1'b1;
                nn_all_ready = 1'b1;
                nn_digit = 4'h3;
                nn_conf = 8'h33;
            end
            if (k == abort_k) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_drop", {nn_inp_rdy, pix_rd_en, busy, done}, 4'b0000);
                chk("abort_rdy_cnt", rdy_cnt, k + 1);
                chk("abort_data", derr, 0);
                return;
            end
            if (k == reset_k) begin
                #2 reset_n = 1'b0;
                #1;
                chk("async_reset_outs", all_outs(), 64'd0);
                @(negedge clk);
                @(negedge clk);
                chk("reset_held_outs", all_outs(), 64'd0);
                reset_n = 1'b1;
                return;
            end
        end
        @(negedge clk);
        start = 1'b0;
        nn_all_ready = 1'b0;
        chk("burst_rdy_cnt", rdy_cnt, NPIX);
        chk("burst_data_errs", derr, 0);
        chk("burst_addr_errs", aerr, 0);
        chk("burst_end", {nn_inp_rdy, pix_rd_en, busy}, 3'b001);
    endtask

    task automatic run_row(input int idx);
        row_t r;
        int done_w = -1;
        int err_w = -1;
        int done_n = 0;
        r = tbl[idx];
        burst(r.abort_k, r.inject_k, -1);
        chk($sformatf("row%0d_start_clears_err", idx), prime_err, 1'b0);
        chk($sformatf("row%0d_start_clears_valid", idx), prime_rv, 1'b0);
        if (r.abort_k >= 0) begin
            chk($sformatf("row%0d_abort_state", idx), {result_valid, err_timeout}, 2'b00);
            @(negedge clk);
            return;
        end
        for (int w = 0; w <= 70; w++) begin
            if (w > 0) @(negedge clk);
            if (done === 1'b1) begin
                done_n++;
                if (done_w < 0) done_w = w;
            end
            if (err_timeout === 1'b1 && err_w < 0) err_w = w;
            nn_all_ready = (w == r.ready_dly);
            nn_digit = (w == r.ready_dly) ? r.digit : ~r.digit;
            nn_conf = (w == r.ready_dly) ? r.conf : ~r.conf;
            abort = (w == r.abort_dly);
        end
        @(negedge clk);
        nn_all_ready = 1'b0;
        abort = 1'b0;
        chk($sformatf("row%0d_done_cycle", idx), done_w, r.exp_done_w);
        chk($sformatf("row%0d_done_count", idx), done_n, (r.exp_done_w >= 0) ? 1 : 0);
        chk($sformatf("row%0d_err_cycle", idx), err_w, r.exp_err_w);
        chk($sformatf("row%0d_flags", idx), {busy, result_valid, err_timeout},
            {1'b0, r.exp_valid, r.exp_err});
        chk($sformatf("row%0d_result", idx), {result_digit, result_conf},
            {r.exp_digit, r.exp_conf});
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        //              rdy abt  inj   abk  dig   conf   done err  v  e  edig  econf
        tbl[0] = '{3,   -1,  -1,   -1, 4'd7, 8'hD2,   4, -1, 1, 0, 4'd7, 8'hD2};
        tbl[1] = '{0,   -1,  -1,   -1, 4'd0, 8'h00,   1, -1, 1, 0, 4'd0, 8'h00};
        tbl[2] = '{63,  -1,  -1,   -1, 4'd9, 8'hFF,  64, -1, 1, 0, 4'd9, 8'hFF};
        tbl[3] = '{64,  -1,  -1,   -1, 4'd2, 8'h11,  -1, 64, 0, 1, 4'd9, 8'hFF};
        tbl[4] = '{-1,  -1, 200,   -1, 4'd6, 8'h66,  -1, 64, 0, 1, 4'd9, 8'hFF};
        tbl[5] = '{10,   5,  -1,   -1, 4'd4, 8'h44,  -1, -1, 0, 0, 4'd9, 8'hFF};
        tbl[6] = '{-1,  -1,  -1,  400, 4'd0, 8'h00,  -1, -1, 0, 0, 4'd9, 8'hFF};
        tbl[7] = '{2,   -1,  -1,   -1, 4'd1, 8'h80,   3, -1, 1, 0, 4'd1, 8'h80};

        for (int a = 0; a < 1024; a++) mem[a] = 8'(a);

        #2 reset_n = 1'b0;
        #1;
        chk("reset_outs_async", all_outs(), 64'd0);
        repeat (2) @(negedge clk);
        chk("reset_outs_held", all_outs(), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_row(i);

        // start together with abort in IDLE must not launch a burst
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            if (busy !== 1'b0 || pix_rd_en !== 1'b0 || nn_inp_rdy !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("idle_start_abort_stays_idle", bad, 0);

        // back-to-back: restart in the first idle cycle after DONE
        for (int a = 0; a < 1024; a++) mem[a] = 8'(a * 37 + 11);
        burst(-1, -1, -1);
        nn_all_ready = 1'b1;
        nn_digit = 4'd5;
        nn_conf = 8'h5A;
        @(negedge clk);
        nn_all_ready = 1'b0;
        nn_digit = 4'd0;
        nn_conf = 8'h00;
        chk("b2b_done", {done, nn_inp_rdy, busy}, 3'b100);
        @(negedge clk);
        chk("b2b_idle_gap", {done, nn_inp_rdy, busy, result_valid}, 4'b0001);
        chk("b2b_result", {result_digit, result_conf}, {4'd5, 8'h5A});
        burst(-1, -1, -1);
        chk("b2b_start_clears_valid", prime_rv, 1'b0);
        chk("b2b_digit_held", prime_digit, 4'd5);
        nn_all_ready = 1'b1;
        nn_digit = 4'd8;
        nn_conf = 8'hC3;
        @(negedge clk);
        nn_all_ready = 1'b0;
        chk("b2b_second_done", done, 1'b1);
        @(negedge clk);
        chk("b2b_second_result", {result_valid, result_digit, result_conf}, {1'b1, 4'd8, 8'hC3});

        // reset mid-stream, then a clean burst from address 0
        for (int a = 0; a < 1024; a++) mem[a] = 8'(a);
        burst(-1, -1, 300);
        @(negedge clk);
        chk("post_reset_idle", {busy, nn_inp_rdy, pix_rd_en}, 3'b000);
        run_row(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
